// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer of ALU_System:
// opcode values, datapath select/function encodings, FSM state and
// instruction-class enums, and register-field helper functions.
package cpu_ctrl_pkg;

    // Opcodes (IR[15:12])
    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ST  = 4'h1;
    localparam logic [3:0] OP_LDI = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_BRA = 4'h8;
    localparam logic [3:0] OP_BEQ = 4'h9;
    localparam logic [3:0] OP_BNE = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // RF / ARF / IR function selects
    localparam logic [1:0] FUN_DEC  = 2'b00;
    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;
    localparam logic [1:0] FUN_CLR  = 2'b11;

    // ALU functions
    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_OR    = 4'b1000;

    // MuxA / MuxB sources
    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;
    localparam logic [1:0] MUX_ARF = 2'b11;

    // ARF output selects and one-hot register selects
    localparam logic [1:0] ARF_OUT_PC = 2'b00;
    localparam logic [1:0] ARF_OUT_AR = 2'b01;
    localparam logic [3:0] ARF_REG_PC = 4'b1000;
    localparam logic [3:0] ARF_REG_AR = 4'b0100;
    localparam logic [3:0] ARF_REG_ALL = 4'b1110;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EX1     = 3'd3,
        ST_EX2     = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_LD   = 4'd1,
        CLS_ST   = 4'd2,
        CLS_LDI  = 4'd3,
        CLS_ALU  = 4'd4,
        CLS_INC  = 4'd5,
        CLS_BRA  = 4'd6,
        CLS_BEQ  = 4'd7,
        CLS_BNE  = 4'd8,
        CLS_HLT  = 4'd9
    } op_class_e;

    // Register field (00=R1 .. 11=R4) to one-hot RF_RSel (R1=1000 .. R4=0001)
    function automatic logic [3:0] reg_onehot(input logic [1:0] field);
        logic [3:0] sel;
        case (field)
            2'b00:   sel = 4'b1000;
            2'b01:   sel = 4'b0100;
            2'b10:   sel = 4'b0010;
            2'b11:   sel = 4'b0001;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Register field to RF read select (100=R1 .. 111=R4)
    function automatic logic [2:0] reg_outsel(input logic [1:0] field);
        return {1'b1, field};
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decoder.sv
// instr_decoder: combinational decode of the upper instruction bits.
// Ports:
//   ir_hi_i      - IR[15:6]: {OP, DST, SRC1, SRC2}
//   op_class_o   - instruction class for the sequencer
//   alu_fun_o    - ALU function for two-operand ALU ops (passA otherwise)
//   dst_onehot_o - one-hot RF_RSel for DST
//   src1_sel_o   - RF read select for SRC1
//   src2_sel_o   - RF read select for SRC2 (IMM[7:6])
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [9:0] ir_hi_i,
    output op_class_e  op_class_o,
    output logic [3:0] alu_fun_o,
    output logic [3:0] dst_onehot_o,
    output logic [2:0] src1_sel_o,
    output logic [2:0] src2_sel_o
);

    logic [3:0] op_s;
    assign op_s         = ir_hi_i[9:6];
    assign dst_onehot_o = reg_onehot(ir_hi_i[5:4]);
    assign src1_sel_o   = reg_outsel(ir_hi_i[3:2]);
    assign src2_sel_o   = reg_outsel(ir_hi_i[1:0]);

    // Opcode to instruction class and ALU function
    always_comb begin
        op_class_o = CLS_NOP;
        alu_fun_o  = ALU_PASSA;
        case (op_s)
            OP_LD:   op_class_o = CLS_LD;
            OP_ST:   op_class_o = CLS_ST;
            OP_LDI:  op_class_o = CLS_LDI;
            OP_ADD:  begin op_class_o = CLS_ALU; alu_fun_o = ALU_ADD; end
            OP_SUB:  begin op_class_o = CLS_ALU; alu_fun_o = ALU_SUB; end
            OP_AND:  begin op_class_o = CLS_ALU; alu_fun_o = ALU_AND; end
            OP_OR:   begin op_class_o = CLS_ALU; alu_fun_o = ALU_OR;  end
            OP_INC:  op_class_o = CLS_INC;
            OP_BRA:  op_class_o = CLS_BRA;
            OP_BEQ:  op_class_o = CLS_BEQ;
            OP_BNE:  op_class_o = CLS_BNE;
            OP_HLT:  op_class_o = CLS_HLT;
            default: op_class_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for ALU_System. Fetches a
// 16-bit instruction as two bytes (low then high) into the IR, then runs
// one or two execute cycles. Outputs are decoded combinationally from the
// registered state, IROut and the Z latch, and are forced idle while
// Reset_n is low.
// Ports: Clock/Reset_n; IROut and ALUOutFlag from the datapath; RF, ARF,
// ALU, IR, memory and mux control selects; Halted and State for debug.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IR_W   = 16
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [IR_W-1:0] IROut,
    input  logic [3:0]      ALUOutFlag,
    output logic [2:0]      RF_OutASel,
    output logic [2:0]      RF_OutBSel,
    output logic [1:0]      RF_FunSel,
    output logic [3:0]      RF_RSel,
    output logic [3:0]      RF_TSel,
    output logic [3:0]      ALU_FunSel,
    output logic [1:0]      ARF_OutCSel,
    output logic [1:0]      ARF_OutDSel,
    output logic [1:0]      ARF_FunSel,
    output logic [3:0]      ARF_RegSel,
    output logic            IR_LH,
    output logic            IR_Enable,
    output logic [1:0]      IR_Funsel,
    output logic            Mem_WR,
    output logic            Mem_CS,
    output logic [1:0]      MuxASel,
    output logic [1:0]      MuxBSel,
    output logic            MuxCSel,
    output logic            Halted,
    output logic [2:0]      State
);

    state_e     state_q, state_d;
    logic       z_q, z_d;
    op_class_e  op_class_s;
    logic [3:0] alu_fun_s;
    logic [3:0] dst_onehot_s;
    logic [2:0] src1_sel_s;
    logic [2:0] src2_sel_s;
    logic       branch_take_s;
    logic       unused_s;

    // Only the Z flag and IR[15:6] steer sequencing; the rest of IMM is datapath-only
    assign unused_s = ^{ALUOutFlag[2:0], IROut[DATA_W-3:0]};
    assign State    = state_q;

    instr_decoder u_decoder (
        .ir_hi_i      (IROut[IR_W-1:DATA_W-2]),
        .op_class_o   (op_class_s),
        .alu_fun_o    (alu_fun_s),
        .dst_onehot_o (dst_onehot_s),
        .src1_sel_o   (src1_sel_s),
        .src2_sel_o   (src2_sel_s)
    );

    assign branch_take_s = (op_class_s == CLS_BRA)
                         | ((op_class_s == CLS_BEQ) &  z_q)
                         | ((op_class_s == CLS_BNE) & ~z_q);

    // State register and Z latch
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_INIT;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    // Next state, Z update and control outputs
    always_comb begin
        state_d     = state_q;
        z_d         = z_q;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = FUN_DEC;
        RF_RSel     = 4'b0000;
        RF_TSel     = 4'b0000;
        ALU_FunSel  = ALU_PASSA;
        ARF_OutCSel = ARF_OUT_PC;
        ARF_OutDSel = ARF_OUT_PC;
        ARF_FunSel  = FUN_DEC;
        ARF_RegSel  = 4'b0000;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = FUN_DEC;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = MUX_ALU;
        MuxBSel     = MUX_ALU;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        // Reset overrides the state decode so nothing is written while asserted
        if (!Reset_n) begin
            state_d = ST_INIT;
            z_d     = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ARF_RegSel = ARF_REG_ALL;
                    ARF_FunSel = FUN_CLR;
                    RF_RSel    = 4'b1111;
                    RF_TSel    = 4'b1111;
                    RF_FunSel  = FUN_CLR;
                    state_d    = ST_FETCH_L;
                end
                ST_FETCH_L, ST_FETCH_H: begin
                    Mem_CS      = 1'b0;
                    ARF_OutDSel = ARF_OUT_PC;
                    IR_Enable   = 1'b1;
                    IR_Funsel   = FUN_LOAD;
                    ARF_RegSel  = ARF_REG_PC;
                    ARF_FunSel  = FUN_INC;
                    IR_LH       = (state_q == ST_FETCH_H);
                    state_d     = (state_q == ST_FETCH_L) ? ST_FETCH_H : ST_EX1;
                end
                ST_EX1: begin
                    state_d = ST_FETCH_L;
                    case (op_class_s)
                        CLS_LD, CLS_ST: begin
                            MuxBSel    = MUX_IMM;
                            ARF_RegSel = ARF_REG_AR;
                            ARF_FunSel = FUN_LOAD;
                            state_d    = ST_EX2;
                        end
                        CLS_LDI: begin
                            MuxASel   = MUX_IMM;
                            RF_RSel   = dst_onehot_s;
                            RF_FunSel = FUN_LOAD;
                        end
                        CLS_ALU: begin
                            RF_OutASel = src1_sel_s;
                            RF_OutBSel = src2_sel_s;
                            ALU_FunSel = alu_fun_s;
                            RF_RSel    = dst_onehot_s;
                            RF_FunSel  = FUN_LOAD;
                            z_d        = ALUOutFlag[3];
                        end
                        CLS_INC: begin
                            // Copy SRC1 into DST now; EX2 increments DST
                            RF_OutASel = src1_sel_s;
                            RF_RSel    = dst_onehot_s;
                            RF_FunSel  = FUN_LOAD;
                            state_d    = ST_EX2;
                        end
                        CLS_BRA, CLS_BEQ, CLS_BNE: begin
                            if (branch_take_s) begin
                                MuxBSel    = MUX_IMM;
                                ARF_RegSel = ARF_REG_PC;
                                ARF_FunSel = FUN_LOAD;
                            end else begin
                                ARF_RegSel = 4'b0000;
                            end
                        end
                        CLS_HLT: state_d = ST_HALT;
                        default: state_d = ST_FETCH_L;
                    endcase
                end
                ST_EX2: begin
                    state_d = ST_FETCH_L;
                    case (op_class_s)
                        CLS_LD: begin
                            Mem_CS      = 1'b0;
                            ARF_OutDSel = ARF_OUT_AR;
                            MuxASel     = MUX_MEM;
                            RF_RSel     = dst_onehot_s;
                            RF_FunSel   = FUN_LOAD;
                        end
                        CLS_ST: begin
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                            ARF_OutDSel = ARF_OUT_AR;
                            RF_OutASel  = src1_sel_s;
                        end
                        CLS_INC: begin
                            RF_RSel   = dst_onehot_s;
                            RF_FunSel = FUN_INC;
                        end
                        default: state_d = ST_FETCH_L;
                    endcase
                end
                ST_HALT: begin
                    Halted  = 1'b1;
                    state_d = ST_HALT;
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

endmodule
